// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_arb_pkg
// Description : Shared definitions for the memory port arbiter: FSM state
//               encoding, wait-counter sizing, default timeout and the
//               little-endian byte-lane extract/merge helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int WAIT_W          = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IF_RD  = 3'd1,
    D_RD   = 3'd2,
    D_WR   = 3'd3,
    RMW_RD = 3'd4,
    RMW_WR = 3'd5,
    ERR    = 3'd6
  } arb_state_e;

  // Lane 0 is bits [7:0]. Returns the addressed byte, zero- or sign-extended.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic        sign_ext);
    logic [7:0] b;
    b = word[{lane, 3'b000} +: 8];
    return sign_ext ? {{24{b[7]}}, b} : {24'h0, b};
  endfunction

  // Replaces the addressed byte lane of word with b.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    w[{lane, 3'b000} +: 8] = b;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_lane_unit.sv
`default_nettype none
// ============================================================================
// Module      : byte_lane_unit
// Description : Combinational byte-lane helper. Produces the load result
//               (sign-extended byte for LB, whole word otherwise) and the
//               read-modify-write merge word for SB.
// Ports       : i_word        - word read from memory
//               i_lane        - byte lane (address bits [1:0])
//               i_byte_access - 1 = byte access
//               i_byte        - byte to merge for SB
//               o_load_data   - load result
//               o_merged_word - i_word with i_byte placed at i_lane
// Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_unit
  import mem_arb_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic        i_byte_access,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged_word
);

  assign o_load_data   = i_byte_access ? lane_extract(i_word, i_lane, 1'b1) : i_word;
  assign o_merged_word = lane_merge(i_word, i_lane, i_byte);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one variable-latency memory port between instruction
//               fetch and the load/store path. Data requests win over fetch.
//               Byte stores are done as read-modify-write. All outputs are
//               registered; done pulses coincide with the return to IDLE.
// Ports       : clk, rst                 - clock, sync active-high reset
//               if_req/if_addr           - fetch request (level)
//               if_rdata/if_done         - fetch result and completion pulse
//               d_read/d_write/d_byte    - load/store request (level)
//               d_addr/d_wdata           - data address and store data
//               d_rdata/d_done           - load result and completion pulse
//               mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack - memory
//               busy                     - FSM not in IDLE
//               bus_error                - sticky timeout / illegal request
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int MEM_AW  = 30,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              d_read,
  input  logic              d_write,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              bus_error
);

  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [1:0]        lane_q, lane_d;
  logic              byte_q, byte_d;
  logic [7:0]        wbyte_q, wbyte_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic              busy_q, busy_d;
  logic              bus_error_q, bus_error_d;

  logic [31:0]       w_load_data;
  logic [31:0]       w_merged_word;
  logic              w_done_cycle;
  logic              w_unused;

  // Fetch addresses are word aligned by construction.
  assign w_unused = &{1'b0, if_addr[1:0]};

  // In the done cycle the requester still holds its level request; block
  // arbitration for that one cycle so the completed request is not re-granted.
  assign w_done_cycle = if_done_q | d_done_q;

  byte_lane_unit u_byte_lane (
    .i_word        (mem_rdata),
    .i_lane        (lane_q),
    .i_byte_access (byte_q),
    .i_byte        (wbyte_q),
    .o_load_data   (w_load_data),
    .o_merged_word (w_merged_word)
  );

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    lane_d      = lane_q;
    byte_d      = byte_q;
    wbyte_d     = wbyte_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    bus_error_d = bus_error_q;

    case (state_q)
      IDLE: begin
        if (!w_done_cycle) begin
          if (d_read && d_write) begin
            state_d     = ERR;
            bus_error_d = 1'b1;
          end else if (d_read || d_write) begin
            mem_req_d  = 1'b1;
            wait_cnt_d = '0;
            mem_addr_d = d_addr[ADDR_W-1:2];
            lane_d     = d_addr[1:0];
            byte_d     = d_byte;
            wbyte_d    = d_wdata[7:0];
            if (d_read) begin
              state_d  = D_RD;
              mem_we_d = 1'b0;
            end else if (d_byte) begin
              state_d  = RMW_RD;
              mem_we_d = 1'b0;
            end else begin
              state_d     = D_WR;
              mem_we_d    = 1'b1;
              mem_wdata_d = d_wdata;
            end
          end else if (if_req) begin
            state_d    = IF_RD;
            mem_req_d  = 1'b1;
            wait_cnt_d = '0;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr[ADDR_W-1:2];
          end
        end
      end

      IF_RD, D_RD, D_WR, RMW_RD, RMW_WR: begin
        if (mem_req_q) begin
          if (mem_ack) begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
            case (state_q)
              IF_RD: begin
                if_rdata_d = mem_rdata;
                if_done_d  = 1'b1;
              end
              D_RD: begin
                d_rdata_d = w_load_data;
                d_done_d  = 1'b1;
              end
              RMW_RD: begin
                // Write phase starts after a single cycle with mem_req low.
                state_d     = RMW_WR;
                mem_we_d    = 1'b1;
                mem_wdata_d = w_merged_word;
              end
              default: d_done_d = 1'b1;
            endcase
          end else if (wait_cnt_q == C_WAIT_LAST) begin
            state_d     = ERR;
            mem_req_d   = 1'b0;
            bus_error_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else if (state_q == RMW_WR) begin
          mem_req_d  = 1'b1;
          wait_cnt_d = '0;
        end
      end

      ERR: mem_req_d = 1'b0;

      default: state_d = ERR;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      lane_q      <= '0;
      byte_q      <= 1'b0;
      wbyte_q     <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      busy_q      <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      lane_q      <= lane_d;
      byte_q      <= byte_d;
      wbyte_q     <= wbyte_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      busy_q      <= busy_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign d_rdata   = d_rdata_q;
  assign d_done    = d_done_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign bus_error = bus_error_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A memory responder
//               with configurable latency runs inside the stimulus process;
//               expected bus transactions and load results come from a
//               word-array reference memory updated with plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_read, d_write, d_byte;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_done;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        busy, bus_error;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .MEM_AW(30), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_read(d_read), .d_write(d_write), .d_byte(d_byte), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .bus_error(bus_error)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] mem     [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
    int          gap;   // cycles from previous ack to this rise; -1 = first
  } txn_t;
  txn_t exp_q[$];

  function automatic logic [31:0] seed_word(input logic [29:0] a);
    return (32'h9E37_79B9 * {2'b00, a}) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    if (!mem.exists(a)) mem[a] = seed_word(a);
    return mem[a];
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] a);
    if (!ref_mem.exists(a)) ref_mem[a] = seed_word(a);
    return ref_mem[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic preload(input logic [29:0] a, input logic [31:0] w);
    mem[a]     = w;
    ref_mem[a] = w;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; d_read = 0; d_write = 0; d_byte = 0;
    d_addr = 0; d_wdata = 0; mem_rdata = 0; mem_ack = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"}, 32'(mem_req), 0);
    check({tag, "_mem_we"}, 32'(mem_we), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_dones"}, 32'({if_done, d_done}), 0);
    check({tag, "_if_rdata"}, if_rdata, 0);
    check({tag, "_d_rdata"}, d_rdata, 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_bus_error"}, 32'(bus_error), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
  endtask

  // Issues an optional data request and an optional fetch in the same cycle,
  // serves the memory with fixed latency and checks every bus transaction,
  // completion timing and returned data against the reference memory.
  task automatic run_ops(input bit do_data, input bit wr, input bit bt,
                         input logic [31:0] daddr, input logic [31:0] wdata,
                         input bit do_fetch, input logic [31:0] faddr,
                         input int lat);
    int          start, last_ack, age;
    bit          prev_req, got_d, got_f;
    txn_t        t, cur;
    logic [31:0] exp_d, exp_f, old, b;
    logic [29:0] wa;
    int          sh;

    exp_q.delete();
    exp_d = 0; exp_f = 0;
    if (do_data) begin
      wa  = daddr[31:2];
      sh  = 8 * int'(daddr[1:0]);
      old = ref_rd(wa);
      if (!wr) begin
        t = '{we: 1'b0, addr: wa, wdata: 0, gap: -1};
        exp_q.push_back(t);
        if (bt) begin
          b     = (old >> sh) & 32'hFF;
          exp_d = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
        end else begin
          exp_d = old;
        end
      end else if (!bt) begin
        t = '{we: 1'b1, addr: wa, wdata: wdata, gap: -1};
        exp_q.push_back(t);
        ref_mem[wa] = wdata;
      end else begin
        t = '{we: 1'b0, addr: wa, wdata: 0, gap: -1};
        exp_q.push_back(t);
        ref_mem[wa] = (old & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
        t = '{we: 1'b1, addr: wa, wdata: ref_mem[wa], gap: 2};
        exp_q.push_back(t);
      end
    end
    if (do_fetch) begin
      exp_f = ref_rd(faddr[31:2]);
      t = '{we: 1'b0, addr: faddr[31:2], wdata: 0, gap: do_data ? 3 : -1};
      exp_q.push_back(t);
    end

    d_read  = do_data & !wr;
    d_write = do_data & wr;
    d_byte  = bt;
    d_addr  = daddr;
    d_wdata = wdata;
    if_req  = do_fetch;
    if_addr = faddr;

    start = cyc; last_ack = -100; age = 0;
    prev_req = 0; got_d = 0; got_f = 0;
    cur = '{we: 1'b0, addr: 0, wdata: 0, gap: 0};
    for (int i = 0; i < 600 && !((got_d || !do_data) && (got_f || !do_fetch)); i++) begin
      tick();
      mem_ack = 1'b0;
      if (mem_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          check("extra_txn", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          check("txn_addr", 32'(mem_addr), 32'(cur.addr));
          check("txn_we", 32'(mem_we), 32'(cur.we));
          if (cur.we) check("txn_wdata", mem_wdata, cur.wdata);
          check("txn_rise_cycle", cyc, (cur.gap < 0) ? start + 1 : last_ack + cur.gap);
          check("busy_in_txn", 32'(busy), 1);
        end
        age = 0;
      end
      if (mem_req) begin
        if (age == lat) begin
          check("addr_stable", 32'(mem_addr), 32'(cur.addr));
          mem_ack = 1'b1;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem_rd(mem_addr);
          last_ack = cyc;
        end
        age++;
      end else begin
        // Stray acks while no request is outstanding must be ignored.
        mem_ack   = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
      if (d_done) begin
        check("d_done_unexpected", 32'(got_d || !do_data), 0);
        check("d_done_cycle", cyc, last_ack + 1);
        if (!wr) check("d_rdata", d_rdata, exp_d);
        check("busy_at_d_done", 32'(busy), 0);
        got_d = 1; d_read = 0; d_write = 0;
      end
      if (if_done) begin
        check("if_done_unexpected", 32'(got_f || !do_fetch), 0);
        check("if_done_cycle", cyc, last_ack + 1);
        check("if_rdata", if_rdata, exp_f);
        got_f = 1; if_req = 0;
      end
      prev_req = mem_req;
    end
    check("all_done", 32'({got_d, got_f}), 32'({do_data, do_fetch}));
    check("txn_queue_empty", exp_q.size(), 0);
    mem_ack = 1'b0;
    d_read = 0; d_write = 0; if_req = 0;
    tick();
    check("no_extra_done", 32'({d_done, if_done}), 0);
  endtask

  initial begin
    int rise, err_cyc, nrise;
    bit saw_done;
    int kind;
    logic [31:0] ra, rw, rf;

    // Reset state
    do_reset();

    // LW: word 0x40, ack after 3 cycles
    preload(30'h40, 32'hDEAD_BEEF);
    run_ops(1, 0, 0, 32'h100, 0, 0, 0, 3);

    // LB sign / zero extension
    preload(30'h40, 32'h8012_3456);
    run_ops(1, 0, 1, 32'h103, 0, 0, 0, 1);
    run_ops(1, 0, 1, 32'h101, 0, 0, 0, 2);

    // SB read-modify-write
    preload(30'h80, 32'h1122_3344);
    run_ops(1, 1, 1, 32'h202, 32'h0000_00AB, 0, 0, 2);
    check("sb_mem_word", mem[30'h80], 32'h11AB_3344);

    // Contention: store and fetch raised together
    preload(30'h90, 32'hCAFE_F00D);
    run_ops(1, 1, 0, 32'h300, 32'h0BAD_CAFE, 1, 32'h240, 2);
    check("sw_mem_word", mem[30'hC0], 32'h0BAD_CAFE);

    // Fetch alone, minimum latency
    run_ops(0, 0, 0, 0, 0, 1, 32'h300, 1);

    // Randomized mix over a small address window
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      ra   = 32'($urandom_range(0, 63));
      rw   = $urandom;
      rf   = 32'($urandom_range(0, 63));
      run_ops(kind != 0, kind >= 3, (kind == 2) || (kind == 4), ra, rw,
              (kind == 0) || ($urandom_range(0, 3) == 0), rf, $urandom_range(1, 4));
    end

    // Illegal d_read & d_write -> ERR
    d_read = 1; d_write = 1; d_addr = 32'h10;
    tick();
    tick();
    check("illegal_bus_error", 32'(bus_error), 1);
    check("illegal_busy", 32'(busy), 1);
    check("illegal_mem_req", 32'(mem_req), 0);
    d_read = 0; d_write = 0;
    tick();
    check("illegal_sticky", 32'(bus_error), 1);
    do_reset();

    // Timeout: memory never acknowledges
    d_read = 1; d_addr = 32'h44;
    rise = -1; err_cyc = -1; saw_done = 0;
    for (int i = 0; i < 400 && err_cyc < 0; i++) begin
      tick();
      if (mem_req && rise < 0) rise = cyc;
      if (bus_error && err_cyc < 0) err_cyc = cyc;
      if (d_done) saw_done = 1;
    end
    check("timeout_cycle", err_cyc - rise, TIMEOUT);
    check("timeout_mem_req", 32'(mem_req), 0);
    check("timeout_busy", 32'(busy), 1);
    check("timeout_no_done", 32'(saw_done), 0);
    d_read = 0;
    tick();
    check("timeout_sticky", 32'(bus_error), 1);
    do_reset();

    // Reset during the RMW write phase
    preload(30'h20, 32'h5566_7788);
    d_write = 1; d_byte = 1; d_addr = 32'h81; d_wdata = 32'h99;
    nrise = 0; rise = 0;
    for (int i = 0; i < 50 && nrise < 2; i++) begin
      tick();
      mem_ack = 1'b0;
      if (mem_req && !rise[0]) begin
        nrise++;
        if (nrise == 1) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_rd(mem_addr);
        end
      end
      rise = {31'b0, mem_req};
    end
    check("rmw_reached_write", nrise, 2);
    check("rmw_write_we", 32'(mem_we), 1);
    check("rmw_write_data", mem_wdata, 32'h5566_9988);
    rst = 1'b1;
    mem_ack = 1'b0;
    tick();
    check_all_zero("rst_mid_rmw");
    rst = 1'b0;
    d_write = 0; d_byte = 0;
    saw_done = 0;
    nrise = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_req) nrise++;
      if (d_done) saw_done = 1;
    end
    check("rst_rmw_no_reissue", nrise, 0);
    check("rst_rmw_no_done", 32'(saw_done), 0);
    check("rst_rmw_mem_kept", mem[30'h20], 32'h5566_7788);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the core's single-ported, variable-latency unified memory between instruction fetch and the load/store path driven by the control unit's MemRead/MemWrite/MemByte decode. Each request is sequenced into one or two memory transactions, and completion is returned as a done pulse. Byte stores are performed as read-modify-write. The block sits between the fetch/MEM stages and the memory model; its busy output feeds the core stall logic.

Parameters:
ADDR_W, 32, byte address width of if_addr/d_addr.
MEM_AW, 30, word address width on the memory side (ADDR_W-2).
TIMEOUT, 255, cycles waiting for mem_ack before bus_error; 8-bit counter.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
if_req  in  1  fetch request; level, held until if_done.
if_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
if_rdata  out  32  fetched word; valid in the if_done cycle.
if_done  out  1  one-cycle completion pulse.
d_read  in  1  load request (MemRead); level, held until d_done.
d_write  in  1  store request (MemWrite); level, held until d_done.
d_byte  in  1  byte access (MemByte).
d_addr  in  ADDR_W  data byte address.
d_wdata  in  32  store data; byte stores use [7:0].
d_rdata  out  32  load result; LB is sign-extended.
d_done  out  1  one-cycle completion pulse.
mem_req  out  1  memory request; held until mem_ack.
mem_we  out  1  1 = write.
mem_addr  out  MEM_AW  word address.
mem_wdata  out  32  write word.
mem_rdata  in  32  read word; valid when mem_ack=1.
mem_ack  in  1  one-cycle acknowledge; earliest one cycle after mem_req rises.
busy  out  1  FSM not in IDLE.
bus_error  out  1  sticky; set on timeout or on d_read&d_write.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; wait counter 0; bus_error cleared. Reset mid-transaction aborts it immediately and issues no done pulse.
- FSM states: IDLE, IF_RD, D_RD, D_WR, RMW_RD, RMW_WR, ERR.
- IDLE arbitration, evaluated each cycle:
  - d_read or d_write has priority over if_req; the data request belongs to an older instruction.
  - Grant latches the address, d_byte, d_wdata and the op type. Requester inputs are ignored after grant.
  - mem_req rises in the cycle after the grant.
- Transitions:
  - d_read -> D_RD.
  - d_write & ~d_byte -> D_WR.
  - d_write & d_byte -> RMW_RD.
  - if_req, with no data request -> IF_RD.
  - d_read & d_write -> ERR.
- IF_RD / D_RD: on mem_ack, capture mem_rdata, pulse the matching done with the data in the same cycle, and return to IDLE.
- LB result: lane = addr[1:0], little-endian (lane 0 = [7:0]). d_rdata = sign-extended byte. LW returns the whole word. addr[1:0] is ignored for word accesses; no alignment trap.
- D_WR: on mem_ack, pulse d_done and go to IDLE.
- RMW_RD: on mem_ack, merge d_wdata[7:0] into the read word at the addressed lane, then go to RMW_WR. mem_req drops for exactly one cycle between the two phases. RMW_WR on mem_ack -> d_done, IDLE.
- Done pulses: the done pulse and the return to IDLE share a cycle. A new grant is possible on the next cycle. Back-to-back throughput is one transaction per ack+2 cycles.
- Memory-side stability: mem_addr, mem_we and mem_wdata are stable while mem_req=1.
- Timeout: the counter resets on every mem_req rise. If it reaches TIMEOUT without an ack, go to ERR.
- ERR: mem_req=0, no done pulses, busy=1, bus_error=1. Only rst leaves ERR; the core treats bus_error like Halted.
- A mem_ack arriving while mem_req=0 is ignored.
- Simultaneous if_req and data request: data wins; fetch waits, its request still held.

Decomposition:
- Shared package mem_arb_pkg:
  - FSM state enum.
  - byte-lane merge/extract functions.
  - TIMEOUT default.
- One sub-module, byte_lane_unit (combinational):
  - extract + sign-extend for LB.
  - merge for SB.
  - reused later by a cache.

Test Plan:
- LW: d_read, d_addr=0x100, mem_ack after 3 cycles with mem_rdata=0xDEADBEEF -> mem_addr=0x40, mem_we=0, d_done pulse with d_rdata=0xDEADBEEF.
- LB sign extension: d_addr=0x103, mem_rdata=0x80123456 -> d_rdata=0xFFFFFF80. With d_addr=0x101 -> 0x00000034.
- SB read-modify-write: d_addr=0x202, d_wdata=0xAB, read returns 0x11223344 -> read then one idle cycle, then write mem_wdata=0x11AB3344 to 0x80, d_done after the second ack only.
- Contention: if_req and d_write asserted in the same cycle -> data write serviced first, fetch granted the cycle after d_done, if_done with its word.
- Timeout: d_read with mem_ack never asserted -> bus_error=1 TIMEOUT cycles after mem_req rise, mem_req=0, no d_done. rst clears to IDLE.
- Reset mid-RMW: rst asserted in RMW_WR -> next cycle all outputs 0, no d_done, memory write not re-issued.
